// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   state_t    : transmitter FSM state encoding (3-bit)
//   PAR_*      : parity mode selectors for the PARITY parameter
//   parity_bit : parity of the low 'nbits' bits of a word, odd or even
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Even mode returns the XOR of the data bits; odd mode returns its inverse.
    function automatic logic parity_bit(input logic [8:0]  data,
                                        input int unsigned nbits,
                                        input int unsigned mode);
        logic x;
        x = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < nbits) x ^= data[i];
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : write strobe, ignored while full (even if a read happens too)
//   wr_data  : word to store
//   rd_en    : pop strobe, ignored while empty
//   rd_data  : head entry, combinational
//   full, empty, count : occupancy status (count is 0..DEPTH)
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Fullness is judged before any same-cycle pop.
    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART serializer fed by a small input FIFO.
//   clk_50m, reset : clock, asynchronous active-high reset
//   clken          : baud tick, one clock wide
//   data_in, wr_en : write port, accepted when wr_en && wr_ready
//   wr_ready       : FIFO not full
//   Tx             : serial line, idle high, LSB first
//   Tx_busy        : FSM not idle
//   byte_end       : one-cycle pulse when the final stop bit is driven
//   fifo_empty, fifo_count : FIFO occupancy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_50m,
    input  logic                 reset,
    input  logic                 clken,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 wr_en,
    output logic                 wr_ready,
    output logic                 Tx,
    output logic                 Tx_busy,
    output logic                 byte_end,
    output logic                 fifo_empty,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    // Reject illegal configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (CNT_W != $clog2(FIFO_DEPTH) + 1) begin : g_bad_cnt_w
        $error("uart_tx_fifo: CNT_W is derived and must not be overridden");
    end

    state_t               r_state,    w_state_nxt;
    logic [DATA_BITS-1:0] r_shreg,    w_shreg_nxt;
    logic [BIT_W-1:0]     r_bit_cnt,  w_bit_cnt_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic                 r_par,      w_par_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_byte_end, w_byte_end_nxt;
    logic                 r_busy;

    logic                 w_pop;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_50m),
        .rst     (reset),
        .wr_en   (wr_en),
        .wr_data (data_in),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign wr_ready   = !w_full;
    assign fifo_empty = w_empty;
    assign fifo_count = w_count;
    assign Tx         = r_tx;
    assign Tx_busy    = r_busy;
    assign byte_end   = r_byte_end;

    // State register.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and datapath updates; only START onward wait for clken.
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_par_nxt      = r_par;
        w_tx_nxt       = r_tx;
        w_byte_end_nxt = 1'b0;
        w_pop          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shreg_nxt    = w_rd_data;
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = 1'b0;
                    w_par_nxt      = parity_bit(9'(w_rd_data), DATA_BITS, PARITY);
                    w_state_nxt    = ST_START;
                end
            end
            ST_START: begin
                if (clken) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clken) begin
                    w_tx_nxt = r_shreg[r_bit_cnt];
                    if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (clken) begin
                    w_tx_nxt    = r_par;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clken) begin
                    w_tx_nxt = 1'b1;
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_byte_end_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output registers; busy tracks the next state so it equals state != IDLE.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_byte_end <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_byte_end <= w_byte_end_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 7N2).
// Expected frames are queued as line-bit vectors (bit 0 = start bit, in time order);
// a monitor collects the line level at every clken while busy and checks on byte_end.
module tb_uart_tx_fifo;

    typedef struct {
        int          id;
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic clk = 1'b0;
    logic clken;
    int   ph;

    logic       rst   [4];
    logic       wr_en [4];
    logic [7:0] din   [3];
    logic [6:0] din3;
    logic       tx    [4];
    logic       busy  [4];
    logic       be    [4];
    logic       wrdy  [4];
    logic       emp   [4];
    logic [2:0] cnt   [4];

    frame_t      exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          be_cnt   [4];
    logic [15:0] cur_bits [4];
    int          cur_len  [4];
    logic        mon_pb   [4];
    logic        mon_pc;

    always #5 clk = ~clk;

    uart_tx_fifo u_8n1 (
        .clk_50m(clk), .reset(rst[0]), .clken(clken), .data_in(din[0]), .wr_en(wr_en[0]),
        .wr_ready(wrdy[0]), .Tx(tx[0]), .Tx_busy(busy[0]), .byte_end(be[0]),
        .fifo_empty(emp[0]), .fifo_count(cnt[0]));

    uart_tx_fifo #(.PARITY(2)) u_8e1 (
        .clk_50m(clk), .reset(rst[1]), .clken(clken), .data_in(din[1]), .wr_en(wr_en[1]),
        .wr_ready(wrdy[1]), .Tx(tx[1]), .Tx_busy(busy[1]), .byte_end(be[1]),
        .fifo_empty(emp[1]), .fifo_count(cnt[1]));

    uart_tx_fifo #(.PARITY(1)) u_8o1 (
        .clk_50m(clk), .reset(rst[2]), .clken(clken), .data_in(din[2]), .wr_en(wr_en[2]),
        .wr_ready(wrdy[2]), .Tx(tx[2]), .Tx_busy(busy[2]), .byte_end(be[2]),
        .fifo_empty(emp[2]), .fifo_count(cnt[2]));

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk_50m(clk), .reset(rst[3]), .clken(clken), .data_in(din3), .wr_en(wr_en[3]),
        .wr_ready(wrdy[3]), .Tx(tx[3]), .Tx_busy(busy[3]), .byte_end(be[3]),
        .fifo_empty(emp[3]), .fifo_count(cnt[3]));

    // Baud tick: one clock in four, changed mid-cycle away from the edge.
    initial begin
        clken = 1'b0;
        ph    = 0;
        forever begin
            @(posedge clk);
            #2;
            ph++;
            clken = (ph % 4 == 0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [15:0] bits, input int len);
        frame_t f;
        f.id = id; f.bits = bits; f.len = len;
        exp_q.push_back(f);
    endtask

    // 8N1 frame model for the longer sequences.
    task automatic push8n1(input logic [7:0] d);
        logic [15:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) b[k+1] = d[k];
        b[9] = 1'b1;
        push(0, b, 10);
    endtask

    // Called at posedge+1; the write lands on the next edge.
    task automatic wr(input int id, input logic [7:0] d);
        wr_en[id] = 1'b1;
        if (id == 3) din3 = d[6:0];
        else         din[id] = d;
        @(posedge clk); #1;
        wr_en[id] = 1'b0;
    endtask

    // Wait for n byte_end pulses, sampled at posedge+2, within a cycle budget.
    task automatic wait_be(input int id, input int n, input int budget);
        int seen;
        int t;
        seen = 0;
        t    = 0;
        while (seen < n && t < budget) begin
            @(posedge clk); #2;
            t++;
            if (be[id]) seen++;
        end
        chk($sformatf("byte_end_wait[%0d]", id), seen, n);
    endtask

    task automatic check_frame(input int i);
        frame_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame[%0d]: got unexpected frame bits=%h len=%0d, expected none",
                     i, cur_bits[i], cur_len[i]);
        end else begin
            e = exp_q.pop_front();
            if (e.id != i || e.bits != cur_bits[i] || e.len != cur_len[i]) begin
                n_fail++;
                $display("FAIL frame[%0d]: got bits=%h len=%0d, expected inst %0d bits=%h len=%0d",
                         i, cur_bits[i], cur_len[i], e.id, e.bits, e.len);
            end
        end
    endtask

    // Monitor: line level captured after every clken edge that found the DUT busy.
    initial begin
        forever begin
            @(negedge clk);
            mon_pc = clken;
            for (int i = 0; i < 4; i++) mon_pb[i] = busy[i];
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (rst[i]) begin
                    cur_len[i]  = 0;
                    cur_bits[i] = '0;
                end else begin
                    if (mon_pc && mon_pb[i]) begin
                        if (cur_len[i] < 16) cur_bits[i][cur_len[i]] = tx[i];
                        cur_len[i]++;
                    end
                    if (be[i]) begin
                        be_cnt[i]++;
                        check_frame(i);
                        cur_len[i]  = 0;
                        cur_bits[i] = '0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bw [6];
        int t;
        int n;
        int b0;
        int bad;

        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; wr_en[i] = 1'b0;
            be_cnt[i] = 0; cur_len[i] = 0; cur_bits[i] = '0;
        end
        for (int i = 0; i < 3; i++) din[i] = '0;
        din3 = '0;
        repeat (3) @(posedge clk);
        #3;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        @(posedge clk); #1;

        // Reset state.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx[%0d]", i), tx[i], 1);
            chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
            chk($sformatf("rst_count[%0d]", i), cnt[i], 0);
            chk($sformatf("rst_empty[%0d]", i), emp[i], 1);
            chk($sformatf("rst_wr_ready[%0d]", i), wrdy[i], 1);
        end

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1.
        push(0, 16'h02AA, 10);
        wr(0, 8'h55);
        wait_be(0, 1, 200);

        // 8O1 0x07: parity slot 0.
        push(2, 16'h040E, 11);
        wr(2, 8'h07);
        wait_be(2, 1, 200);

        // 8E1 0x07 written on a clken edge while idle: parity slot 1.
        push(1, 16'h060E, 11);
        t = 0;
        do begin
            @(posedge clk); #3;
            t++;
        end while (!clken && t < 10);
        chk("align_clken", clken, 1);
        wr_en[1] = 1'b1; din[1] = 8'h07;
        @(posedge clk); #1;
        wr_en[1] = 1'b0;
        chk("wr_clken_busy", busy[1], 0);
        chk("wr_clken_count", cnt[1], 1);
        @(posedge clk); #1;
        chk("start_busy", busy[1], 1);
        chk("start_tx_held", tx[1], 1);
        repeat (2) @(posedge clk);
        #1;
        chk("tx_before_clken", tx[1], 1);
        @(posedge clk); #1;
        chk("tx_start_bit", tx[1], 0);
        wait_be(1, 1, 200);

        // 7N2 back-to-back 0x7F, 0x00: no gap after the second stop period.
        push(3, 16'h03FE, 10);
        push(3, 16'h0300, 10);
        wr(3, 8'h7F);
        wr(3, 8'h00);
        wait_be(3, 1, 200);
        n = 0; t = 0;
        while (tx[3] !== 1'b0 && t < 40) begin
            @(posedge clk); #1;
            t++;
            if (clken) n++;
        end
        chk("b2b_gap_clkens", n, 1);
        wait_be(3, 1, 200);

        // Burst of six writes into depth 4: five accepted, sixth dropped.
        bw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int k = 0; k < 5; k++) push8n1(bw[k]);
        b0 = be_cnt[0];
        for (int k = 0; k < 6; k++) begin
            wr_en[0] = 1'b1; din[0] = bw[k];
            if (k == 4) chk("wr_ready_count3", wrdy[0], 1);
            if (k == 5) chk("wr_ready_full", wrdy[0], 0);
            @(posedge clk); #1;
        end
        wr_en[0] = 1'b0;
        chk("count_full", cnt[0], 4);
        chk("wr_ready_still_full", wrdy[0], 0);
        wait_be(0, 5, 1500);
        chk("burst_frames", be_cnt[0] - b0, 5);
        chk("burst_empty", emp[0], 1);

        // Write and pop in the same cycle at count 2.
        push8n1(8'hA1); push8n1(8'hB2); push8n1(8'hC3); push8n1(8'hD4);
        wr(0, 8'hA1);
        wr(0, 8'hB2);
        wr(0, 8'hC3);
        chk("count_two", cnt[0], 2);
        wait_be(0, 1, 200);
        chk("count_two_idle", cnt[0], 2);
        wr_en[0] = 1'b1; din[0] = 8'hD4;
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        chk("count_wr_pop", cnt[0], 2);
        chk("busy_after_pop", busy[0], 1);
        wait_be(0, 3, 600);

        // Reset during data bit 3 of 0xA5 with two words queued.
        wr(0, 8'hA5);
        wr(0, 8'h3C);
        wr(0, 8'h96);
        t = 0;
        while (cur_len[0] < 5 && t < 200) begin
            @(posedge clk); #3;
            t++;
        end
        chk("reach_bit3", cur_len[0], 5);
        chk("bit3_low", tx[0], 0);
        chk("queued_two", cnt[0], 2);
        b0 = be_cnt[0];
        rst[0] = 1'b1;
        #1;
        chk("rst_mid_tx", tx[0], 1);
        chk("rst_mid_count", cnt[0], 0);
        chk("rst_mid_busy", busy[0], 0);
        chk("rst_mid_byte_end", be[0], 0);
        repeat (3) @(posedge clk);
        #3;
        rst[0] = 1'b0;
        bad = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);
        chk("no_byte_end_after_reset", be_cnt[0] - b0, 0);

        // Every queued frame must have been seen.
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
